// File: rtl/fpga_cfg_pkg.sv
`default_nettype none
// ============================================================================
// fpga_cfg_pkg
// Shared fixed-point configuration and math-library types.
// Revision: 1.1 - divider latency constant and state type
// ============================================================================
package fpga_cfg_pkg;

   localparam int FP_WIDTH       = 32;
   localparam int FP_QINT        = 16;
   localparam int FP_QFRAC       = 16;
   // Accept-to-valid_out edge count of fx_div, for scheduler alignment
   localparam int FP_DIV_LATENCY = FP_WIDTH + FP_QFRAC + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } div_state_e;

endpackage
`default_nettype wire

// File: rtl/fx_div.sv
`default_nettype none
// ============================================================================
// fx_div
// Sequential signed Q-format divider: restoring radix-2, one quotient bit/clk.
// Revision: 1.0 - initial release
// ============================================================================
module fx_div
   import fpga_cfg_pkg::*;
#(
   parameter int WIDTH = FP_WIDTH,
   parameter int QINT  = FP_QINT,
   parameter int QFRAC = FP_QFRAC
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   output logic                    ready_in,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] result,
   output logic                    valid_out,
   output logic                    dbz,
   output logic                    ovf
);

   localparam int ITER  = WIDTH + QFRAC;
   localparam int CNT_W = $clog2(ITER);

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ITER - 1);
   localparam logic [WIDTH-1:0] c_max_pos  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_max_neg  = {1'b1, {(WIDTH-1){1'b0}}};

   generate
      if (QINT + QFRAC != WIDTH) begin : g_bad_qformat
         $error("fx_div: QINT + QFRAC must equal WIDTH");
      end
   endgenerate

   // Returns {quotient bit, new remainder}; remainder always stays below |b|
   function automatic logic [WIDTH:0] restore_step(
      input logic [WIDTH-1:0] rem,
      input logic             din,
      input logic [WIDTH-1:0] dvs
   );
      logic [WIDTH:0] sh;
      sh = {rem, din};
      if (sh >= {1'b0, dvs}) begin
         restore_step = {1'b1, WIDTH'(sh - {1'b0, dvs})};
      end else begin
         restore_step = {1'b0, sh[WIDTH-1:0]};
      end
   endfunction

   div_state_e       r_state;
   div_state_e       w_next;
   logic [ITER-1:0]  r_dividend;
   logic [ITER-1:0]  r_quot;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_rem;
   logic [CNT_W-1:0] r_cnt;
   logic             r_neg;
   logic             r_a_neg;
   logic             r_dbz_pend;

   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_step;
   logic [WIDTH-1:0] w_q_lo;
   logic             w_q_hi_nz;
   logic             w_ovf_pos;
   logic             w_ovf_neg;

   // Unsigned view keeps |-2^(WIDTH-1)| exact
   assign w_a_mag   = a[WIDTH-1] ? $unsigned(-a) : $unsigned(a);
   assign w_b_mag   = b[WIDTH-1] ? $unsigned(-b) : $unsigned(b);
   assign w_step    = restore_step(r_rem, r_dividend[ITER-1], r_divisor);

   assign w_q_lo    = r_quot[WIDTH-1:0];
   assign w_q_hi_nz = |r_quot[ITER-1:WIDTH];
   assign w_ovf_pos = !r_neg && (w_q_hi_nz || w_q_lo[WIDTH-1]);
   assign w_ovf_neg =  r_neg && (w_q_hi_nz || (w_q_lo[WIDTH-1] && (|w_q_lo[WIDTH-2:0])));

   always_comb begin
      w_next   = r_state;
      ready_in = 1'b0;
      case (r_state)
         IDLE: begin
            ready_in = 1'b1;
            if (valid_in) begin
               w_next = (b == '0) ? FINISH : CALC;
            end
         end
         CALC: begin
            if (r_cnt == '0) begin
               w_next = FINISH;
            end
         end
         FINISH: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_dividend <= '0;
         r_quot     <= '0;
         r_divisor  <= '0;
         r_rem      <= '0;
         r_cnt      <= '0;
         r_neg      <= 1'b0;
         r_a_neg    <= 1'b0;
         r_dbz_pend <= 1'b0;
         result     <= '0;
         valid_out  <= 1'b0;
         dbz        <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         r_state   <= w_next;
         valid_out <= 1'b0;
         case (r_state)
            IDLE: begin
               if (valid_in) begin
                  r_dividend <= {w_a_mag, {QFRAC{1'b0}}};
                  r_divisor  <= w_b_mag;
                  r_neg      <= a[WIDTH-1] ^ b[WIDTH-1];
                  r_a_neg    <= a[WIDTH-1];
                  r_dbz_pend <= (b == '0);
                  r_cnt      <= c_cnt_last;
                  r_rem      <= '0;
                  r_quot     <= '0;
               end
            end
            CALC: begin
               r_dividend <= r_dividend << 1;
               r_rem      <= w_step[WIDTH-1:0];
               r_quot     <= {r_quot[ITER-2:0], w_step[WIDTH]};
               r_cnt      <= r_cnt - CNT_W'(1);
            end
            FINISH: begin
               valid_out <= 1'b1;
               if (r_dbz_pend) begin
                  result <= r_a_neg ? c_max_neg : c_max_pos;
                  dbz    <= 1'b1;
                  ovf    <= 1'b0;
               end else if (w_ovf_pos) begin
                  result <= c_max_pos;
                  dbz    <= 1'b0;
                  ovf    <= 1'b1;
               end else if (w_ovf_neg) begin
                  result <= c_max_neg;
                  dbz    <= 1'b0;
                  ovf    <= 1'b1;
               end else begin
                  // -0 in two's complement is 0, so a zero quotient stays zero
                  result <= r_neg ? -w_q_lo : w_q_lo;
                  dbz    <= 1'b0;
                  ovf    <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire
